// File: rtl/alt_vipvfr131_common_control_packet_encoder.sv
`timescale 1ns/1ps
// Inserts an Avalon-ST video control packet (header + width/height/interlace body) ahead of video frames.
// Optional build macro ALT_VIPVFR131_CTRL_PKT_EVERY_FRAME_EN: insert before every video frame instead of only after a new ctrl_load.
module alt_vipvfr131_common_control_packet_encoder #(
   parameter int unsigned BITS_PER_SYMBOL  = 8,
   parameter int unsigned SYMBOLS_PER_BEAT = 3
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   output logic                                        din_ready,
   input  logic                                        din_valid,
   input  logic                                        din_sop,
   input  logic                                        din_eop,
   input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
   input  logic                                        dout_ready,
   output logic                                        dout_valid,
   output logic                                        dout_sop,
   output logic                                        dout_eop,
   output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
   input  logic [15:0]                                 ctrl_width,
   input  logic [15:0]                                 ctrl_height,
   input  logic [3:0]                                  ctrl_interlaced,
   input  logic                                        ctrl_load,
   output logic                                        ctrl_busy
);

   localparam int unsigned DW       = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
   localparam int unsigned NUM_BODY = (9 + SYMBOLS_PER_BEAT - 1) / SYMBOLS_PER_BEAT;

   typedef enum logic [1:0] {PASS, HDR, BODY} state_t;

   state_t        state;
   state_t        state_next;
   logic          in_packet;
   logic          pending;
   logic          resume;
   logic [15:0]   shadow_width;
   logic [15:0]   shadow_height;
   logic [3:0]    shadow_interlaced;
   logic [15:0]   send_width;
   logic [15:0]   send_height;
   logic [3:0]    send_interlaced;
   logic [3:0]    beat_cnt;
   logic          insert_needed;
   logic          trigger;
   logic          capture;
   logic          accept;
   logic          last_beat;
   logic [3:0]    nib [16];
   logic [DW-1:0] body_data;

`ifdef ALT_VIPVFR131_CTRL_PKT_EVERY_FRAME_EN
   assign insert_needed = 1'b1;
`else
   assign insert_needed = pending;
`endif

   // resume lets the held video sop beat through once after an insertion
   assign trigger   = !in_packet && !resume && din_valid && din_sop &&
                      (din_data[3:0] == 4'h0) && insert_needed;
   assign capture   = (state == PASS) && trigger;
   assign accept    = din_valid && din_ready;
   assign last_beat = (beat_cnt == 4'(NUM_BODY - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= PASS;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         PASS:    if (trigger) state_next = HDR;
         HDR:     if (dout_ready) state_next = BODY;
         BODY:    if (dout_ready && last_beat) state_next = PASS;
         default: state_next = PASS;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_packet         <= 1'b0;
         pending           <= 1'b1;
         resume            <= 1'b0;
         shadow_width      <= 16'd640;
         shadow_height     <= 16'd480;
         shadow_interlaced <= '0;
         send_width        <= '0;
         send_height       <= '0;
         send_interlaced   <= '0;
         beat_cnt          <= '0;
      end else begin
         if (ctrl_load) begin
            shadow_width      <= ctrl_width;
            shadow_height     <= ctrl_height;
            shadow_interlaced <= ctrl_interlaced;
         end
         if (ctrl_load) begin
            pending <= 1'b1;
         end else if (capture) begin
            pending <= 1'b0;
         end
         if (capture) begin
            send_width      <= shadow_width;
            send_height     <= shadow_height;
            send_interlaced <= shadow_interlaced;
         end
         if (accept) begin
            resume <= 1'b0;
            if (din_eop) begin
               in_packet <= 1'b0;
            end else if (din_sop) begin
               in_packet <= 1'b1;
            end
         end else if (state == BODY && dout_ready && last_beat) begin
            resume <= 1'b1;
         end
         if (state == HDR) begin
            beat_cnt <= '0;
         end else if (state == BODY && dout_ready) begin
            beat_cnt <= beat_cnt + 4'd1;
         end
      end
   end

   // nibble k of the body lands in symbol (k mod SYMBOLS_PER_BEAT) of beat (k / SYMBOLS_PER_BEAT)
   always_comb begin
      for (int unsigned k = 0; k < 16; k++) begin
         nib[k] = '0;
      end
      nib[0] = send_width[15:12];
      nib[1] = send_width[11:8];
      nib[2] = send_width[7:4];
      nib[3] = send_width[3:0];
      nib[4] = send_height[15:12];
      nib[5] = send_height[11:8];
      nib[6] = send_height[7:4];
      nib[7] = send_height[3:0];
      nib[8] = send_interlaced;
      body_data = '0;
      for (int unsigned s = 0; s < SYMBOLS_PER_BEAT; s++) begin
         body_data[s*BITS_PER_SYMBOL +: 4] = nib[4'(beat_cnt * SYMBOLS_PER_BEAT + s)];
      end
   end

   always_comb begin
      din_ready  = 1'b0;
      dout_valid = 1'b0;
      dout_sop   = 1'b0;
      dout_eop   = 1'b0;
      dout_data  = '0;
      ctrl_busy  = 1'b0;
      case (state)
         PASS: begin
            dout_data = din_data;
            dout_sop  = din_sop;
            dout_eop  = din_eop;
            if (!trigger) begin
               din_ready  = dout_ready;
               dout_valid = din_valid;
            end
         end
         HDR: begin
            dout_valid     = 1'b1;
            dout_sop       = 1'b1;
            dout_data[3:0] = 4'hF;
            ctrl_busy      = 1'b1;
         end
         BODY: begin
            dout_valid = 1'b1;
            dout_eop   = last_beat;
            dout_data  = body_data;
            ctrl_busy  = 1'b1;
         end
         default: ;
      endcase
      if (!rst_n) begin
         din_ready  = 1'b0;
         dout_valid = 1'b0;
      end
   end

endmodule

// File: tb/tb_alt_vipvfr131_common_control_packet_encoder.sv
`timescale 1ns/1ps
// Scoreboard bench for the control packet encoder (8 bits x 3 symbols).
module tb_alt_vipvfr131_common_control_packet_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        din_ready, din_valid, din_sop, din_eop;
   logic [23:0] din_data;
   logic        dout_ready, dout_valid, dout_sop, dout_eop;
   logic [23:0] dout_data;
   logic [15:0] ctrl_width, ctrl_height;
   logic [3:0]  ctrl_interlaced;
   logic        ctrl_load, ctrl_busy;

   alt_vipvfr131_common_control_packet_encoder #(
      .BITS_PER_SYMBOL (8),
      .SYMBOLS_PER_BEAT(3)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .din_ready      (din_ready),
      .din_valid      (din_valid),
      .din_sop        (din_sop),
      .din_eop        (din_eop),
      .din_data       (din_data),
      .dout_ready     (dout_ready),
      .dout_valid     (dout_valid),
      .dout_sop       (dout_sop),
      .dout_eop       (dout_eop),
      .dout_data      (dout_data),
      .ctrl_width     (ctrl_width),
      .ctrl_height    (ctrl_height),
      .ctrl_interlaced(ctrl_interlaced),
      .ctrl_load      (ctrl_load),
      .ctrl_busy      (ctrl_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sop;
      logic        eop;
      logic [23:0] data;
   } beat_t;

   typedef struct {
      logic        load;
      logic [15:0] w;
      logic [15:0] h;
      logic [3:0]  i;
      logic [23:0] b1;
      logic [23:0] b2;
      logic [23:0] b3;
   } vec_t;

   beat_t       exp_q[$];
   vec_t        vecs[4];
   int          compared = 0;
   int          mismatched = 0;
   int          busy_cycles = 0;
   int          ins_beats = 0;
   int          bp_i = 0;
   logic        bp_en = 1'b0;
   logic [3:0]  pat = 4'b1001;
   logic        prev_stall = 1'b0;
   logic [23:0] prev_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [23:0] body_beat(input logic [15:0] w, input logic [15:0] h,
                                             input logic [3:0] i, input int b);
      logic [3:0]  n[12];
      logic [23:0] r;
      n = '{w[15:12], w[11:8], w[7:4], w[3:0], h[15:12], h[11:8], h[7:4], h[3:0],
            i, 4'h0, 4'h0, 4'h0};
      r = '0;
      for (int s = 0; s < 3; s++) r[s*8 +: 4] = n[b*3 + s];
      return r;
   endfunction

   task automatic push(input logic sop, input logic eop, input logic [23:0] data);
      beat_t e;
      e.sop = sop; e.eop = eop; e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic push_lit(input logic [23:0] b1, input logic [23:0] b2, input logic [23:0] b3);
      push(1'b1, 1'b0, 24'h00000F);
      push(1'b0, 1'b0, b1);
      push(1'b0, 1'b0, b2);
      push(1'b0, 1'b1, b3);
   endtask

   task automatic push_insert(input logic [15:0] w, input logic [15:0] h, input logic [3:0] i);
      push_lit(body_beat(w, h, i, 0), body_beat(w, h, i, 1), body_beat(w, h, i, 2));
   endtask

   task automatic monitor_step();
      beat_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
         return;
      end
      if (ctrl_busy) begin
         busy_cycles++;
         check("din_ready_busy", {31'b0, din_ready}, 32'd0);
      end
      if (prev_stall) check("stall_data", {8'b0, dout_data}, {8'b0, prev_data});
      if (dout_valid && dout_ready) begin
         if (ctrl_busy) ins_beats++;
         if (exp_q.size() == 0) begin
            check("unexpected_beat", {6'b0, dout_sop, dout_eop, dout_data}, 32'hFFFFFFFF);
         end else begin
            e = exp_q.pop_front();
            check("dout_beat", {6'b0, dout_sop, dout_eop, dout_data}, {6'b0, e.sop, e.eop, e.data});
         end
      end
      prev_stall = ctrl_busy && dout_valid && !dout_ready;
      prev_data  = dout_data;
   endtask

   task automatic send_beat(input logic sop, input logic eop, input logic [23:0] data);
      logic acc;
      bit   done;
      push(sop, eop, data);
      din_valid = 1'b1; din_sop = sop; din_eop = eop; din_data = data;
      done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         acc = din_ready;
         @(posedge clk);
         #1;
         if (acc) done = 1;
      end
      if (!done) check("din_accept_timeout", 32'd0, 32'd1);
      din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
   endtask

   task automatic send_frame(input logic [3:0] ty, input logic [23:0] base);
      send_beat(1'b1, 1'b0, {base[23:4], ty});
      send_beat(1'b0, 1'b0, base ^ 24'h111111);
      send_beat(1'b0, 1'b1, base + 24'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [15:0] w, input logic [15:0] h, input logic [3:0] i);
      ctrl_width = w; ctrl_height = h; ctrl_interlaced = i; ctrl_load = 1'b1;
      @(posedge clk);
      #1;
      ctrl_load = 1'b0;
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      din_valid = 1'b1; din_sop = 1'b1; din_eop = 1'b0; din_data = '0;
      ctrl_width = '0; ctrl_height = '0; ctrl_interlaced = '0; ctrl_load = 1'b0;
      dout_ready = 1'b1;

      vecs[0] = '{1'b0, 16'd0,    16'd0,    4'h0, 24'h080200, 24'h010000, 24'h00000E};
      vecs[1] = '{1'b1, 16'd1920, 16'd1080, 4'h3, 24'h080700, 24'h040000, 24'h030803};
      vecs[2] = '{1'b1, 16'hABCD, 16'h1234, 4'h5, 24'h0C0B0A, 24'h02010D, 24'h050403};
      vecs[3] = '{1'b1, 16'hFFFF, 16'h0000, 4'hF, 24'h0F0F0F, 24'h00000F, 24'h0F0000};

      fork
         forever begin
            @(negedge clk);
            monitor_step();
         end
         forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
               dout_ready = pat[bp_i % 4];
               bp_i++;
            end else begin
               dout_ready = 1'b1;
            end
         end
      join_none

      // reset state with a video sop already presented
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_din_ready", {31'b0, din_ready}, 32'd0);
      check("rst_dout_valid", {31'b0, dout_valid}, 32'd0);
      check("rst_ctrl_busy", {31'b0, ctrl_busy}, 32'd0);
      @(posedge clk);
      #1;
      din_valid = 1'b0; din_sop = 1'b0; rst_n = 1'b1;
      idle(2);

      // non-zero type while pending: forwarded in the same cycle
      push(1'b1, 1'b0, 24'hABCDE5);
      din_valid = 1'b1; din_sop = 1'b1; din_eop = 1'b0; din_data = 24'hABCDE5;
      @(negedge clk);
      check("t5_dout_valid", {31'b0, dout_valid}, 32'd1);
      check("t5_dout_data", {8'b0, dout_data}, 32'h00ABCDE5);
      check("t5_din_ready", {31'b0, din_ready}, 32'd1);
      check("t5_ctrl_busy", {31'b0, ctrl_busy}, 32'd0);
      @(posedge clk);
      #1;
      din_valid = 1'b0; din_sop = 1'b0;
      send_beat(1'b0, 1'b1, 24'h00BEEF);
      busy_cycles = 0;
      send_frame(4'hF, 24'h777770);
      idle(3);
      check("typeF_busy", busy_cycles, 32'd0);

      // table: optional load, then a video frame with a full insertion
      for (int v = 0; v < 4; v++) begin
         if (vecs[v].load) load(vecs[v].w, vecs[v].h, vecs[v].i);
         busy_cycles = 0;
         push_lit(vecs[v].b1, vecs[v].b2, vecs[v].b3);
         send_frame(4'h0, 24'h123450 + 24'(v * 16'h1000));
         idle(3);
         check("table_busy", busy_cycles, 32'd4);
      end

      // second frame without a new load
      busy_cycles = 0;
`ifdef ALT_VIPVFR131_CTRL_PKT_EVERY_FRAME_EN
      push_lit(vecs[3].b1, vecs[3].b2, vecs[3].b3);
      send_frame(4'h0, 24'h5A5A50);
      idle(3);
      check("second_frame_busy", busy_cycles, 32'd4);
`else
      send_frame(4'h0, 24'h5A5A50);
      idle(3);
      check("second_frame_busy", busy_cycles, 32'd0);
`endif

      // downstream backpressure during insertion
      load(16'h1234, 16'h5678, 4'h1);
      ins_beats = 0;
      busy_cycles = 0;
      bp_i = 0;
      bp_en = 1'b1;
      push_insert(16'h1234, 16'h5678, 4'h1);
      send_frame(4'h0, 24'h246800);
      bp_en = 1'b0;
      idle(3);
      check("bp_inserted_beats", ins_beats, 32'd4);

      // reset pulse during the second body beat
      load(16'h0100, 16'h0200, 4'h2);
      push(1'b1, 1'b0, 24'h00000F);
      push(1'b0, 1'b0, body_beat(16'h0100, 16'h0200, 4'h2, 0));
      din_valid = 1'b1; din_sop = 1'b1; din_eop = 1'b0; din_data = 24'h135790;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (ctrl_busy) seen = 1;
      end
      if (!seen) check("busy_wait_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      din_valid = 1'b0; din_sop = 1'b0;
      @(negedge clk);
      check("midrst_dout_valid", {31'b0, dout_valid}, 32'd0);
      check("midrst_ctrl_busy", {31'b0, ctrl_busy}, 32'd0);
      check("midrst_din_ready", {31'b0, din_ready}, 32'd0);
      check("midrst_beats_out", exp_q.size(), 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(2);
      busy_cycles = 0;
      push_insert(16'd640, 16'd480, 4'h0);
      send_frame(4'h0, 24'h9ABC00);
      idle(3);
      check("post_rst_busy", busy_cycles, 32'd4);

      for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
